// File: rtl/trashbin_pkg.sv
// Shared types and constants for the Trashbin control sequencer.
package trashbin_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_EXEC   = 3'd1,
    ST_MEM    = 3'd2,
    ST_COMMIT = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_TIMEOUT  = 2'b01;
  localparam logic [1:0] FC_MISALIGN = 2'b10;
  localparam logic [1:0] FC_RDWR     = 2'b11;

  // Wait counter width; kept at least 1 bit so MAX_WAIT=0 still elaborates.
  function automatic int wait_cnt_w(input int max_wait);
    int w;
    w = $clog2(max_wait + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/trashbin_mem_timeout.sv
// Clearable wait-state counter; timeout is high while the count sits at MAX_WAIT.
import trashbin_pkg::*;

module trashbin_mem_timeout #(
  parameter int MAX_WAIT = 15
) (
  input  logic CoreClock,
  input  logic CoreReset_n,
  input  logic clr,
  input  logic inc,
  output logic timeout
);
  localparam int CW = wait_cnt_w(MAX_WAIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge CoreClock) begin
    if (!CoreReset_n)         cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (inc && !timeout) cnt <= cnt + 1'b1;
  end

  assign timeout = (cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/trashbin_sequencer.sv
// Handshaked fetch/exec/mem/commit sequencer for the Trashbin core; every output is a register.
import trashbin_pkg::*;

module trashbin_sequencer #(
  parameter int unsigned              ADDR_WIDTH   = 32,
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]    RESET_VECTOR = '0,
  parameter int unsigned              INSTR_BYTES  = 4,
  parameter int                       MAX_WAIT     = 15
) (
  input  logic                  CoreClock,
  input  logic                  CoreReset_n,
  output logic [ADDR_WIDTH-1:0] AddressBus,
  input  logic [DATA_WIDTH-1:0] DataReadBus,
  output logic [DATA_WIDTH-1:0] DataWriteBus,
  output logic                  ReadAssert,
  output logic                  WriteAssert,
  input  logic                  MemReady,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  InstrValid,
  output logic [ADDR_WIDTH-1:0] ProgramCounter,
  input  logic                  ExecDone,
  input  logic                  ExecMemRead,
  input  logic                  ExecMemWrite,
  input  logic [ADDR_WIDTH-1:0] ExecMemAddr,
  input  logic [DATA_WIDTH-1:0] ExecMemData,
  input  logic                  BranchTaken,
  input  logic [ADDR_WIDTH-1:0] BranchTarget,
  output logic [DATA_WIDTH-1:0] LoadData,
  output logic                  LoadValid,
  output logic                  Fault,
  output logic [1:0]            FaultCode,
  output logic [2:0]            DebugState
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);

  typedef struct packed {
    logic                  rd;
    logic                  br;
    logic [ADDR_WIDTH-1:0] target;
  } exec_op_t;

  state_e                state, state_nxt;
  exec_op_t              op, op_nxt;
  logic [ADDR_WIDTH-1:0] pc_nxt, addr_nxt;
  logic [DATA_WIDTH-1:0] ir_nxt, wdata_nxt, ld_nxt;
  logic                  rd_nxt, wr_nxt, iv_nxt, lv_nxt, flt_nxt;
  logic [1:0]            fc_nxt, fault_code;
  logic                  go_fault, tmo_clr, tmo, req;

  assign req        = ReadAssert | WriteAssert;
  assign DebugState = state;

  trashbin_mem_timeout #(.MAX_WAIT(MAX_WAIT)) u_tmo (
    .CoreClock   (CoreClock),
    .CoreReset_n (CoreReset_n),
    .clr         (tmo_clr),
    .inc         (req & ~MemReady),
    .timeout     (tmo)
  );

  always_comb begin
    state_nxt  = state;
    op_nxt     = op;
    pc_nxt     = ProgramCounter;
    addr_nxt   = AddressBus;
    ir_nxt     = Instruction;
    wdata_nxt  = DataWriteBus;
    ld_nxt     = LoadData;
    rd_nxt     = ReadAssert;
    wr_nxt     = WriteAssert;
    iv_nxt     = 1'b0;
    lv_nxt     = 1'b0;
    flt_nxt    = Fault;
    fc_nxt     = FaultCode;
    tmo_clr    = 1'b0;
    go_fault   = 1'b0;
    fault_code = FC_NONE;

    case (state)
      ST_FETCH: begin
        // No request out yet only right after reset; issue it from the current PC.
        if (!req) begin
          rd_nxt   = 1'b1;
          addr_nxt = ProgramCounter;
          tmo_clr  = 1'b1;
        end else if (MemReady) begin
          ir_nxt    = DataReadBus;
          rd_nxt    = 1'b0;
          iv_nxt    = 1'b1;
          state_nxt = ST_EXEC;
        end else if (tmo) begin
          go_fault   = 1'b1;
          fault_code = FC_TIMEOUT;
        end
      end
      ST_EXEC: begin
        if (ExecDone) begin
          op_nxt = '{rd: ExecMemRead, br: BranchTaken, target: BranchTarget};
          if (ExecMemRead && ExecMemWrite) begin
            go_fault   = 1'b1;
            fault_code = FC_RDWR;
          end else if (ExecMemRead || ExecMemWrite) begin
            rd_nxt    = ExecMemRead;
            wr_nxt    = ExecMemWrite;
            addr_nxt  = ExecMemAddr;
            wdata_nxt = ExecMemData;
            tmo_clr   = 1'b1;
            state_nxt = ST_MEM;
          end else begin
            state_nxt = ST_COMMIT;
          end
        end
      end
      ST_MEM: begin
        if (MemReady) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          state_nxt = ST_COMMIT;
          if (op.rd) begin
            ld_nxt = DataReadBus;
            lv_nxt = 1'b1;
          end
        end else if (tmo) begin
          go_fault   = 1'b1;
          fault_code = FC_TIMEOUT;
        end
      end
      ST_COMMIT: begin
        if (op.br && ((op.target & ALIGN_MASK) != '0)) begin
          go_fault   = 1'b1;
          fault_code = FC_MISALIGN;
        end else begin
          pc_nxt    = op.br ? op.target : ProgramCounter + PC_STEP;
          rd_nxt    = 1'b1;
          addr_nxt  = pc_nxt;
          tmo_clr   = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FAULT: ;
      default: begin
        go_fault   = 1'b1;
        fault_code = FaultCode;
      end
    endcase

    if (go_fault) begin
      state_nxt = ST_FAULT;
      rd_nxt    = 1'b0;
      wr_nxt    = 1'b0;
      flt_nxt   = 1'b1;
      fc_nxt    = fault_code;
    end
  end

  always_ff @(posedge CoreClock) begin
    if (!CoreReset_n) begin
      state          <= ST_FETCH;
      op             <= '0;
      ProgramCounter <= RESET_VECTOR;
      AddressBus     <= '0;
      Instruction    <= '0;
      DataWriteBus   <= '0;
      LoadData       <= '0;
      ReadAssert     <= 1'b0;
      WriteAssert    <= 1'b0;
      InstrValid     <= 1'b0;
      LoadValid      <= 1'b0;
      Fault          <= 1'b0;
      FaultCode      <= FC_NONE;
    end else begin
      state          <= state_nxt;
      op             <= op_nxt;
      ProgramCounter <= pc_nxt;
      AddressBus     <= addr_nxt;
      Instruction    <= ir_nxt;
      DataWriteBus   <= wdata_nxt;
      LoadData       <= ld_nxt;
      ReadAssert     <= rd_nxt;
      WriteAssert    <= wr_nxt;
      InstrValid     <= iv_nxt;
      LoadValid      <= lv_nxt;
      Fault          <= flt_nxt;
      FaultCode      <= fc_nxt;
    end
  end

endmodule
